// File: rtl/bcd2bin_seq.sv
// Sequential 2-digit BCD to 8-bit binary converter (reverse double-dabble, one bit per cycle).
// Optional invalid-digit check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [3:0] Most,
  input  logic [3:0] Least,
  output logic [7:0] Bin,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state;
  logic [7:0] bcd;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] bin_q;
  logic [7:0] bcd_shifted;
  logic [7:0] bcd_step;
  logic [7:0] acc_step;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q;
  logic err_pend;
  logic bad_digit;

  assign bad_digit = (Most > 4'd9) || (Least > 4'd9);
`endif

  // One reverse double-dabble step: shift right into the accumulator, then
  // pull each BCD nibble that reached 8 or more back down by 3.
  always_comb begin
    bcd_shifted = {1'b0, bcd[7:1]};
    acc_step    = {bcd[0], acc[7:1]};
    bcd_step    = bcd_shifted;
    if (bcd_shifted[7:4] >= 4'd8) bcd_step[7:4] = bcd_shifted[7:4] - 4'd3;
    if (bcd_shifted[3:0] >= 4'd8) bcd_step[3:0] = bcd_shifted[3:0] - 4'd3;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      bcd      <= 8'h00;
      acc      <= 8'h00;
      cnt      <= 3'd0;
      bin_q    <= 8'h00;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q    <= 1'b0;
      err_pend <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            bcd   <= {Most, Least};
            acc   <= 8'h00;
            cnt   <= 3'd0;
            state <= S_SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_pend <= bad_digit;
`endif
          end
        end
        S_SHIFT: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          if (err_pend) begin
            // Invalid digits skip the shift sequence entirely.
            bin_q    <= 8'h00;
            err_q    <= 1'b1;
            err_pend <= 1'b0;
            state    <= S_DONE;
          end else begin
`endif
            bcd <= bcd_step;
            acc <= acc_step;
            cnt <= cnt + 3'd1;
            // Result is captured on the final step so it is valid throughout DONE.
            if (cnt == 3'd7) begin
              bin_q <= acc_step;
              state <= S_DONE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
              err_q <= 1'b0;
`endif
            end
`ifdef BCD2BIN_DIGIT_CHECK_EN
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Bin       = bin_q;
  assign Busy      = (state == S_SHIFT);
  assign Done      = (state == S_DONE);
  assign dbg_state = state;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter: none; widths fixed (2 BCD digits in, 8-bit binary out).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-low reset; sampled on rising edge of CLK only.
REQ-004 Start  input  1  request conversion; sampled only in IDLE.
REQ-005 Most  input  4  BCD tens digit; sampled with Start.
REQ-006 Least  input  4  BCD units digit; sampled with Start.
REQ-007 Bin  output  8  binary result, range 0..99; held until the next load.
REQ-008 Busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-009 Done  output  1  one-cycle pulse, high when Bin/Err are valid.
REQ-010 Err  output  1  invalid-digit flag; valid with Done (see Configuration).

Function
REQ-011 Algorithm SHALL be reverse double-dabble: 8-bit BCD shift register {tens,units} and 8-bit binary accumulator.
REQ-012 Each SHIFT cycle: shift the BCD register right by 1; its LSB enters accumulator MSB; the accumulator shifts right by 1; then subtract 3 from each BCD nibble whose value >= 8.
REQ-013 States: IDLE, SHIFT, DONE; the encoding is free.
REQ-014 IDLE: if Start=1 at edge N, load {Most,Least}, clear the accumulator and the iteration counter, go to SHIFT; otherwise stay.
REQ-015 SHIFT: perform one step per edge; after the 8th step (edge N+8) go to DONE.
REQ-016 DONE: Bin SHALL be driven with the final accumulator value; Done=1 for exactly one cycle (cycle after edge N+8); return to IDLE at the next edge.
REQ-017 Latency: Start at edge N -> Done high in the cycle following edge N+8 (9 cycles, fixed for all valid inputs).
REQ-018 Busy=1 in SHIFT only; Busy=0 in IDLE and DONE.
REQ-019 Start while in SHIFT or DONE SHALL be ignored; no queuing.
REQ-020 Start held continuously: a new conversion SHALL begin on the first edge in IDLE after Done; back-to-back throughput is 1 result per 10 cycles.
REQ-021 Most/Least changing after load SHALL NOT affect the result.
REQ-022 Bin SHALL update only in DONE; between conversions it holds the last result.
REQ-023 Iteration counter: 3 bits, wraps 7->0 on the final step; no other terminal state.

Reset
REQ-024 RST=0 at a rising edge: state=IDLE, Bin=0x00, Busy=0, Done=0, Err=0, and the counter and shift registers cleared.
REQ-025 Reset asserted mid-conversion SHALL abort it, with no Done pulse; Start is honoured on the first edge after RST returns high.
REQ-026 Reset SHALL take priority over Start on the same edge.

Configuration
REQ-027 Macro BCD2BIN_DIGIT_CHECK_EN defined: at load, if Most>9 or Least>9, go directly to DONE (Done in the cycle after edge N+1) with Err=1 and Bin=0x00; valid digits give Err=0.
REQ-028 Macro BCD2BIN_DIGIT_CHECK_EN undefined: no check; Err is tied to 0; invalid digits take the normal 9-cycle path and produce an unspecified Bin.

Verification
REQ-029 Reset, then Most=9 Least=9 Start pulse at edge N -> Busy for 8 cycles, Done at cycle after N+8, Bin=0x63, Err=0.
REQ-030 Most=0 Least=0 -> Bin=0x00; Most=4 Least=5 -> Bin=0x2D; Most=1 Least=0 -> Bin=0x0A; each with 9-cycle latency.
REQ-031 Start pulsed again at N+3 with Most=2 Least=2 during a conversion of 0x99 -> ignored, result 0x63; a single Done pulse.
REQ-032 RST=0 at edge N+4 mid-conversion -> no Done; Bin=0x00; Busy=0 next cycle; Start after release converts normally.
REQ-033 With BCD2BIN_DIGIT_CHECK_EN: Most=1 Least=0xA -> Done at cycle after N+1, Err=1, Bin=0x00; next Most=3 Least=7 -> Bin=0x25, Err=0.
REQ-034 Start held high for 30 cycles with Most=5 Least=0 -> Done pulses every 10 cycles, Bin=0x32 each time.
